// File: rtl/rob.sv
// Reorder buffer: allocates tags at dispatch, captures CDB results, retires in order.
// Commit side drives the rst tag-clear strobe and the architectural register write.
module rob #(
    parameter int DEPTH  = 32,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              disp_valid,
    input  logic [4:0]        disp_dest,
    input  logic              disp_wr,
    output logic              disp_ready,
    output logic [TAG_W-1:0]  disp_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic [TAG_W-1:0]  src_tag_a,
    input  logic [TAG_W-1:0]  src_tag_b,
    output logic              src_ready_a,
    output logic              src_ready_b,
    output logic [DATA_W-1:0] src_data_a,
    output logic [DATA_W-1:0] src_data_b,
    output logic              RB_valid_rst,
    output logic [TAG_W-1:0]  RB_tag_rst,
    output logic              commit_wen,
    output logic [4:0]        commit_addr,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W:0]    count
);

    logic [TAG_W:0]    head;
    logic [TAG_W:0]    tail;
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  rdy;
    logic [DEPTH-1:0]  wr_q;
    logic [4:0]        dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [TAG_W-1:0]  head_idx;
    logic [TAG_W-1:0]  tail_idx;
    logic              full;
    logic              commit;
    logic              disp_fire;
    logic              cdb_hit;

    assign head_idx = head[TAG_W-1:0];
    assign tail_idx = tail[TAG_W-1:0];

    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return 32'(t) < DEPTH;
    endfunction

    // Wrap bit toggles when the index rolls past DEPTH-1.
    function automatic logic [TAG_W:0] ptr_inc(input logic [TAG_W:0] p);
        if (p[TAG_W-1:0] == TAG_W'(DEPTH - 1))
            return {~p[TAG_W], {TAG_W{1'b0}}};
        else
            return p + (TAG_W+1)'(1);
    endfunction

    assign full       = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
    assign disp_ready = ~full;
    assign disp_tag   = tail_idx;
    assign disp_fire  = disp_valid & disp_ready & ~flush;
    assign cdb_hit    = cdb_valid & tag_ok(cdb_tag) & busy[cdb_tag];

    always_comb begin
        count = {1'b0, tail_idx} - {1'b0, head_idx};
        if (head[TAG_W] != tail[TAG_W])
            count = count + (TAG_W+1)'(DEPTH);
    end

    assign commit = busy[head_idx] & rdy[head_idx] & ~flush;

    always_comb begin
        RB_valid_rst = 1'b0;
        RB_tag_rst   = '0;
        commit_wen   = 1'b0;
        commit_addr  = '0;
        commit_data  = '0;
        if (commit) begin
            RB_valid_rst = 1'b1;
            RB_tag_rst   = head_idx;
            commit_wen   = wr_q[head_idx] & (dest_q[head_idx] != 5'd0);
            commit_addr  = dest_q[head_idx];
            commit_data  = data_q[head_idx];
        end
    end

    // Result in the MSB-side ready bit; a live CDB broadcast beats stored data.
    function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] t);
        if (!tag_ok(t))
            return '0;
        else if (cdb_valid && cdb_tag == t && busy[t])
            return {1'b1, cdb_data};
        else if (busy[t] && rdy[t])
            return {1'b1, data_q[t]};
        else
            return '0;
    endfunction

    always_comb begin
        {src_ready_a, src_data_a} = lookup(src_tag_a);
        {src_ready_b, src_data_b} = lookup(src_tag_b);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            busy <= '0;
            rdy  <= '0;
            wr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            busy <= '0;
            rdy  <= '0;
        end else begin
            if (cdb_hit) begin
                rdy[cdb_tag]    <= 1'b1;
                data_q[cdb_tag] <= cdb_data;
            end
            if (commit) begin
                busy[head_idx] <= 1'b0;
                rdy[head_idx]  <= 1'b0;
                head           <= ptr_inc(head);
            end
            if (disp_fire) begin
                busy[tail_idx]   <= 1'b1;
                rdy[tail_idx]    <= 1'b0;
                wr_q[tail_idx]   <= disp_wr;
                dest_q[tail_idx] <= disp_dest;
                tail             <= ptr_inc(tail);
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: a scoreboard queue holds expected commits,
// a negedge monitor pops and compares whenever RB_valid_rst is seen.
module tb_rob;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        disp_valid;
    logic [4:0]  disp_dest;
    logic        disp_wr;
    logic        disp_ready;
    logic [4:0]  disp_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [4:0]  src_tag_a;
    logic [4:0]  src_tag_b;
    logic        src_ready_a;
    logic        src_ready_b;
    logic [31:0] src_data_a;
    logic [31:0] src_data_b;
    logic        RB_valid_rst;
    logic [4:0]  RB_tag_rst;
    logic        commit_wen;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;
    logic [5:0]  count;

    rob dut (
        .clock(clock), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_dest(disp_dest), .disp_wr(disp_wr),
        .disp_ready(disp_ready), .disp_tag(disp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .src_tag_a(src_tag_a), .src_tag_b(src_tag_b),
        .src_ready_a(src_ready_a), .src_ready_b(src_ready_b),
        .src_data_a(src_data_a), .src_data_b(src_data_b),
        .RB_valid_rst(RB_valid_rst), .RB_tag_rst(RB_tag_rst),
        .commit_wen(commit_wen), .commit_addr(commit_addr),
        .commit_data(commit_data), .count(count)
    );

    typedef struct {
        logic [4:0]  tag;
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (RB_valid_rst === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL commit_unexpected: got tag=%0d addr=%0d data=%h, want none",
                         RB_tag_rst, commit_addr, commit_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (RB_tag_rst !== e.tag || commit_wen !== e.wen ||
                    commit_addr !== e.addr || commit_data !== e.data) begin
                    n_err++;
                    $display("FAIL commit: got tag=%0d wen=%0b addr=%0d data=%h, want tag=%0d wen=%0b addr=%0d data=%h",
                             RB_tag_rst, commit_wen, commit_addr, commit_data,
                             e.tag, e.wen, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] t, input logic w, input logic [4:0] a,
                        input logic [31:0] d);
        exp_t e;
        e.tag = t;
        e.wen = w;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d pending, want 0", name, sb.size());
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        disp_valid = 1'b0;
        disp_dest = '0;
        disp_wr = 1'b0;
        cdb_valid = 1'b0;
        cdb_tag = '0;
        cdb_data = '0;
        src_tag_a = '0;
        src_tag_b = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        chk("reset_count", 64'(count), 64'd0);
        chk("reset_disp_ready", 64'(disp_ready), 64'd1);
        chk("reset_disp_tag", 64'(disp_tag), 64'd0);
        chk("reset_rb_valid", 64'(RB_valid_rst), 64'd0);

        // in-order commit with out-of-order completion
        disp_valid = 1'b1;
        disp_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            disp_dest = 5'(3 + i);
            chk("inorder_disp_tag", 64'(disp_tag), 64'(i));
            tick();
        end
        disp_valid = 1'b0;
        cdb_valid = 1'b1;
        cdb_tag = 5'd2;
        cdb_data = 32'hC;
        tick();
        chk("inorder_no_early_commit", 64'(RB_valid_rst), 64'd0);
        cdb_tag = 5'd0;
        cdb_data = 32'hA;
        push(5'd0, 1'b1, 5'd3, 32'hA);
        push(5'd1, 1'b1, 5'd4, 32'hB);
        push(5'd2, 1'b1, 5'd5, 32'hC);
        chk("inorder_still_no_commit", 64'(RB_valid_rst), 64'd0);
        tick();
        chk("inorder_commit0_visible", 64'(RB_valid_rst), 64'd1);
        cdb_tag = 5'd1;
        cdb_data = 32'hB;
        tick();
        cdb_valid = 1'b0;
        chk("inorder_commit1_visible", 64'(RB_valid_rst), 64'd1);
        tick();
        chk("inorder_commit2_visible", 64'(RB_valid_rst), 64'd1);
        drain("inorder");
        chk("inorder_count", 64'(count), 64'd0);

        // full and wrap
        pulse_reset();
        disp_valid = 1'b1;
        disp_wr = 1'b1;
        for (int i = 0; i < 32; i++) begin
            disp_dest = 5'(i);
            chk("fill_disp_tag", 64'(disp_tag), 64'(i));
            tick();
        end
        chk("full_disp_ready", 64'(disp_ready), 64'd0);
        chk("full_count", 64'(count), 64'd32);
        disp_dest = 5'd1;
        tick();
        disp_valid = 1'b0;
        chk("full_33rd_ignored", 64'(count), 64'd32);
        cdb_valid = 1'b1;
        cdb_tag = 5'd0;
        cdb_data = 32'h100;
        push(5'd0, 1'b0, 5'd0, 32'h100);
        tick();
        cdb_valid = 1'b0;
        disp_valid = 1'b1;
        disp_dest = 5'd9;
        chk("full_commit_strobe", 64'(RB_valid_rst), 64'd1);
        chk("full_no_bypass_ready", 64'(disp_ready), 64'd0);
        tick();
        chk("full_commit_drop_disp", 64'(count), 64'd31);
        disp_wr = 1'b0;
        chk("wrap_disp_ready", 64'(disp_ready), 64'd1);
        chk("wrap_disp_tag", 64'(disp_tag), 64'd0);
        tick();
        disp_valid = 1'b0;
        chk("wrap_count", 64'(count), 64'd32);

        // operand bypass from CDB
        cdb_valid = 1'b1;
        cdb_tag = 5'd7;
        cdb_data = 32'h77;
        src_tag_a = 5'd7;
        src_tag_b = 5'd8;
        #1;
        chk("bypass_ready_a", 64'(src_ready_a), 64'd1);
        chk("bypass_data_a", 64'(src_data_a), 64'h77);
        chk("bypass_ready_b", 64'(src_ready_b), 64'd0);
        chk("bypass_data_b", 64'(src_data_b), 64'd0);
        tick();
        cdb_valid = 1'b0;
        chk("stored_ready_a", 64'(src_ready_a), 64'd1);
        chk("stored_data_a", 64'(src_data_a), 64'h77);
        drain("bypass");

        // no-write commit, dispatch to commit in 2 cycles
        pulse_reset();
        disp_valid = 1'b1;
        disp_dest = 5'd6;
        disp_wr = 1'b0;
        tick();
        disp_valid = 1'b0;
        cdb_valid = 1'b1;
        cdb_tag = 5'd0;
        cdb_data = 32'h55;
        push(5'd0, 1'b0, 5'd6, 32'h55);
        tick();
        cdb_valid = 1'b0;
        chk("nowr_rb_valid", 64'(RB_valid_rst), 64'd1);
        chk("nowr_wen", 64'(commit_wen), 64'd0);
        drain("nowr");

        // flush squashes a ready head
        pulse_reset();
        disp_valid = 1'b1;
        disp_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            disp_dest = 5'(10 + i);
            tick();
        end
        disp_valid = 1'b0;
        cdb_valid = 1'b1;
        cdb_tag = 5'd0;
        cdb_data = 32'h1234;
        tick();
        cdb_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_rb_valid", 64'(RB_valid_rst), 64'd0);
        chk("flush_wen", 64'(commit_wen), 64'd0);
        tick();
        flush = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_disp_tag", 64'(disp_tag), 64'd0);
        cdb_valid = 1'b1;
        cdb_tag = 5'd2;
        cdb_data = 32'hDEAD;
        src_tag_a = 5'd2;
        #1;
        chk("flush_old_tag_bypass", 64'(src_ready_a), 64'd0);
        tick();
        cdb_valid = 1'b0;
        chk("flush_old_tag_stored", 64'(src_ready_a), 64'd0);
        chk("flush_count_after_cdb", 64'(count), 64'd0);
        tick();
        chk("flush_no_commit", 64'(RB_valid_rst), 64'd0);

        // async reset mid-stream
        disp_valid = 1'b1;
        disp_dest = 5'd12;
        disp_wr = 1'b1;
        tick();
        disp_valid = 1'b0;
        cdb_valid = 1'b1;
        cdb_tag = 5'd0;
        cdb_data = 32'h99;
        tick();
        cdb_valid = 1'b0;
        chk("areset_pre_commit", 64'(RB_valid_rst), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("areset_rb_valid", 64'(RB_valid_rst), 64'd0);
        chk("areset_wen", 64'(commit_wen), 64'd0);
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_disp_ready", 64'(disp_ready), 64'd1);
        tick();
        reset = 1'b0;
        tick();
        chk("areset_idle", 64'(RB_valid_rst), 64'd0);

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL final_queue: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer for the out-of-order MIPS core: allocates tags for dispatched instructions and captures results from the common data bus (CDB).
- Retires entries strictly in program order.
- Drives the commit-side tag/valid pair that the register status table (rst) consumes as RB_tag_rst/RB_valid_rst to clear pending mappings, and the architectural register-file write.
- Serves ready operand values to reservation stations by tag.

Parameters:
DEPTH, 32, number of entries; power of two, at most 2**TAG_W
TAG_W, 5, tag width; tag = entry index
DATA_W, 32, result width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
flush  in  1  synchronous squash of all entries
disp_valid  in  1  dispatch request
disp_dest  in  5  destination architectural register
disp_wr  in  1  instruction writes a register
disp_ready  out  1  entry available (count < DEPTH)
disp_tag  out  TAG_W  tag allocated this cycle (= tail index); fed to rst Wdata_rst
cdb_valid  in  1  result broadcast
cdb_tag  in  TAG_W  producing entry
cdb_data  in  DATA_W  result value
src_tag_a / src_tag_b  in  TAG_W  operand lookup tags
src_ready_a / src_ready_b  out  1  value available for that tag
src_data_a / src_data_b  out  DATA_W  value for that tag
RB_valid_rst  out  1  commit strobe to rst
RB_tag_rst  out  TAG_W  tag of committing entry
commit_wen  out  1  register-file write enable
commit_addr  out  5  register-file write address
commit_data  out  DATA_W  register-file write data
count  out  TAG_W+1  occupied entries

Behaviour:
- Storage and pointers:
  - Per entry: busy, ready, wr, dest[4:0], data.
  - head and tail are TAG_W+1 bits. The MSB is the wrap bit; the low bits index entries.
  - empty = (head == tail). full = low bits equal and wrap bits differ.
- Reset (async): head = tail = 0, all busy/ready = 0, data = 0.
  - Consequences: count = 0, disp_ready = 1, disp_tag = 0, every commit/src output = 0.
- Dispatch accept = disp_valid & disp_ready & ~flush. On the clock edge:
  - entry[tail] gets busy = 1, ready = 0, dest, wr.
  - tail increments and wraps modulo 2*DEPTH.
- disp_tag = tail low bits, combinational and valid while disp_valid.
- disp_ready = ~full. A commit in the same cycle does not make a slot available to a dispatch while full (no bypass).
- CDB capture: if cdb_valid and entry[cdb_tag].busy, set ready = 1 and data = cdb_data at the edge. A CDB write to a non-busy entry is ignored.
- Commit condition: entry[head].busy & entry[head].ready & ~flush. At most one commit per cycle. Commit outputs are combinational from head state.
  - RB_valid_rst = 1 and RB_tag_rst = head low bits for every commit, including wr = 0.
  - commit_wen = commit & wr & (dest != 0); commit_addr = dest; commit_data = data.
  - On the edge, entry[head].busy and ready clear and head increments.
  - When no commit is taken, all commit outputs are 0.
- Latency:
  - A CDB result becomes commit-visible at the earliest the cycle after capture.
  - Dispatch to earliest commit is 2 cycles.
- Operand lookup (combinational):
  - src_ready_x = 1 if cdb_valid & cdb_tag == src_tag_x & entry busy; src_data_x = cdb_data (CDB bypass wins).
  - Otherwise src_ready_x = entry busy & ready, with src_data_x = entry data.
  - Else src_ready_x = 0 and src_data_x = 0.
- Simultaneous dispatch, CDB and commit in one cycle are all legal and update independently. count = tail - head.
- Flush takes priority over everything:
  - Commit outputs are forced to 0 that cycle.
  - At the edge, all busy/ready clear and head = tail = 0. The dispatch that cycle is dropped.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Test Plan:
- Reset then idle: count = 0, disp_ready = 1, disp_tag = 0, RB_valid_rst = 0.
- In-order commit:
  - Dispatch rd = 3, 4, 5 (tags 0, 1, 2).
  - CDB tag 2 = 0xC, then tag 0 = 0xA, then tag 1 = 0xB.
  - Commits: tag 0 (addr 3, 0xA), tag 1 (addr 4, 0xB), tag 2 (addr 5, 0xC) on consecutive cycles. No commit before tag 0 is ready.
- Full and wrap:
  - Dispatch 32 entries: disp_ready = 0 and count = 32; a 33rd dispatch is ignored.
  - Complete and commit tag 0, then dispatch again: disp_tag = 0 and count = 32.
- Bypass and no-write commits:
  - With cdb_valid, cdb_tag = 7 and src_tag_a = 7 on a busy entry: src_ready_a = 1, src_data_a = cdb_data in the same cycle.
  - Commit of an entry with wr = 0 or dest = 0: RB_valid_rst = 1 and commit_wen = 0.
- Flush with 5 entries, head ready: RB_valid_rst = 0 that cycle; next cycle count = 0 and disp_tag = 0. A CDB to an old tag afterwards has no effect.
- Async reset mid-stream: outputs clear before the next clock edge.
